// File: rtl/ttest_0905_pkg.sv
// Shared types and widths for the 4-literal clause evaluator.
// Literal count, true-count width, literal index type and count/index bundle.
package ttest_0905_pkg;

  localparam int LIT_N  = 4;
  localparam int TCNT_W = 3;

  typedef logic [1:0]        lit_idx_t;
  typedef logic [TCNT_W-1:0] tcnt_t;

  typedef struct packed {
    tcnt_t    cnt;
    lit_idx_t idx;
  } lit_sum_t;

endpackage

// File: rtl/ttest_0905_popcnt4.sv
// 4-bit popcount plus lowest-true-literal index (a=bit0 wins).
// Ports: lits[3:0] in; sum.cnt (0..4), sum.idx (0 when none true) out.
module ttest_0905_popcnt4
  import ttest_0905_pkg::*;
(
  input  logic [LIT_N-1:0] lits,
  output lit_sum_t         sum
);

  // Adder form keeps X on any literal visible on the count.
  always_comb begin
    sum.cnt = tcnt_t'(lits[0])
            + tcnt_t'(lits[1])
            + tcnt_t'(lits[2])
            + tcnt_t'(lits[3]);
  end

  // Ternary chain gives a > b > c > d priority; no match -> 0.
  always_comb begin
    sum.idx = lits[0] ? lit_idx_t'(0) :
              lits[1] ? lit_idx_t'(1) :
              lits[2] ? lit_idx_t'(2) :
              lits[3] ? lit_idx_t'(3) :
                        lit_idx_t'(0);
  end

endmodule

// File: rtl/ttest_0905.sv
// 4-literal clause evaluator for BCP: combinational status flags plus an
// optional conflict-edge counter (enabled by macro TTEST0905_STATS_EN).
// Ports: clock, reset (sync, active-high); a..d literal values in;
// e, true_cnt, single_true, conflict, first_idx combinational out;
// conflict_cnt registered saturating count of conflict rising edges.
module ttest_0905
  import ttest_0905_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             e,
  output tcnt_t            true_cnt,
  output logic             single_true,
  output logic             conflict,
  output lit_idx_t         first_idx,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [LIT_N-1:0] lits;
  lit_sum_t         sum;

  assign lits = {d, c, b, a};

  ttest_0905_popcnt4 u_popcnt (
    .lits (lits),
    .sum  (sum)
  );

  assign e           = |lits;
  assign conflict    = ~e;
  assign true_cnt    = sum.cnt;
  assign single_true = (sum.cnt == tcnt_t'(1));
  assign first_idx   = sum.idx;

`ifdef TTEST0905_STATS_EN

  logic conflict_q;

  // Counts 0->1 transitions of conflict; a held conflict counts once.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_q   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict_q <= conflict;
      if (conflict && !conflict_q && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

`else

  assign conflict_cnt = '0;

  logic unused_clk_rst;
  assign unused_clk_rst = ^{clock, reset};

`endif

endmodule

// File: tb/tb_ttest_0905.sv
// Bench for ttest_0905: combinational truth table and conflict counter.
// Counter expectations follow TTEST0905_STATS_EN (0 when undefined).
module tb_ttest_0905;
  import ttest_0905_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       e8, st8, cf8, e2, st2, cf2;
  tcnt_t      tc8, tc2;
  lit_idx_t   fi8, fi2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic     e;
    tcnt_t    tc;
    logic     st;
    logic     cf;
    lit_idx_t fi;
  } comb_t;

  comb_t cq[$];
  int    k8q[$];
  int    k2q[$];

  logic mq = 1'b0;
  int   m8 = 0;
  int   m2 = 0;

  always #5 clock = ~clock;

  ttest_0905 #(.CNT_W(8)) u8 (
    .clock(clock), .reset(reset),
    .a(a), .b(b), .c(c), .d(d),
    .e(e8), .true_cnt(tc8), .single_true(st8),
    .conflict(cf8), .first_idx(fi8), .conflict_cnt(cnt8)
  );

  ttest_0905 #(.CNT_W(2)) u2 (
    .clock(clock), .reset(reset),
    .a(a), .b(b), .c(c), .d(d),
    .e(e2), .true_cnt(tc2), .single_true(st2),
    .conflict(cf2), .first_idx(fi2), .conflict_cnt(cnt2)
  );

  function automatic comb_t model(input logic [3:0] v);
    comb_t r;
    int n = 0;
    int f = -1;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        n++;
        if (f < 0) f = i;
      end
    end
    r.e  = (n > 0);
    r.tc = tcnt_t'(n);
    r.st = (n == 1);
    r.cf = (n == 0);
    r.fi = (f < 0) ? lit_idx_t'(0) : lit_idx_t'(f);
    return r;
  endfunction

  // One clock cycle: drive, predict counters, compare after the edge.
  task automatic cyc(input logic [3:0] v, input logic rst,
                     input string nm);
    logic cfm;
    int   x8, x2;
    cfm = (v == 4'b0000);
    {d, c, b, a} = v;
    reset = rst;
`ifdef TTEST0905_STATS_EN
    if (rst) begin
      mq = 1'b0; m8 = 0; m2 = 0;
    end else begin
      if (cfm && !mq) begin
        if (m8 != 255) m8++;
        if (m2 != 3) m2++;
      end
      mq = cfm;
    end
`endif
    k8q.push_back(m8);
    k2q.push_back(m2);
    @(posedge clock);
    #1;
    x8 = k8q.pop_front();
    x2 = k2q.pop_front();
    checks++;
    if (cnt8 !== 8'(x8)) begin
      errors++;
      $display("FAIL %s cnt8 got %0d want %0d", nm, cnt8, x8);
    end
    checks++;
    if (cnt2 !== 2'(x2)) begin
      errors++;
      $display("FAIL %s cnt2 got %0d want %0d", nm, cnt2, x2);
    end
  endtask

  task automatic test_reset();
    cyc(4'b0001, 1'b1, "reset0");
    cyc(4'b0000, 1'b1, "reset1");
  endtask

  // Spec vectors first, then the full table; reset toggled to show
  // it has no influence on the combinational side.
  task automatic test_comb();
    logic [3:0] vec[$];
    comb_t      x;
    vec = '{4'b1000, 4'b1111, 4'b0000};
    for (int i = 0; i < 16; i++) vec.push_back(4'(i));
    foreach (vec[k]) begin
      {d, c, b, a} = vec[k];
      reset = vec[k][0];
      cq.push_back(model(vec[k]));
      #1;
      x = cq.pop_front();
      checks++;
      if (e8 !== x.e || tc8 !== x.tc || st8 !== x.st ||
          cf8 !== x.cf || fi8 !== x.fi) begin
        errors++;
        $display("FAIL comb8 v=%b got %b%0d%b%b%0d want %b%0d%b%b%0d",
                 vec[k], e8, tc8, st8, cf8, fi8,
                 x.e, x.tc, x.st, x.cf, x.fi);
      end
      checks++;
      if (e2 !== x.e || tc2 !== x.tc || st2 !== x.st ||
          cf2 !== x.cf || fi2 !== x.fi) begin
        errors++;
        $display("FAIL comb2 v=%b got %b%0d%b%b%0d want %b%0d%b%b%0d",
                 vec[k], e2, tc2, st2, cf2, fi2,
                 x.e, x.tc, x.st, x.cf, x.fi);
      end
    end
    reset = 1'b1;
  endtask

  // conflict 0,1,1,0,1 -> two rising edges.
  task automatic test_toggle();
    cyc(4'b0001, 1'b1, "tg_rst0");
    cyc(4'b0001, 1'b1, "tg_rst1");
    cyc(4'b0001, 1'b0, "tg0");
    cyc(4'b0000, 1'b0, "tg1");
    cyc(4'b0000, 1'b0, "tg2");
    cyc(4'b0100, 1'b0, "tg3");
    cyc(4'b0000, 1'b0, "tg4");
  endtask

  task automatic test_saturate();
    cyc(4'b0010, 1'b1, "sat_rst");
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1000, 1'b0, "sat_hi");
      cyc(4'b0000, 1'b0, "sat_pulse");
    end
    cyc(4'b0001, 1'b0, "sat_hold");
  endtask

  task automatic test_reset_conflict();
    comb_t x;
    cyc(4'b0001, 1'b0, "rc_pre");
    cyc(4'b0000, 1'b1, "rc_rst");
    x = model(4'b0000);
    checks++;
    if (cf8 !== x.cf || e8 !== x.e) begin
      errors++;
      $display("FAIL rc_comb got cf=%b e=%b want cf=%b e=%b",
               cf8, e8, x.cf, x.e);
    end
    cyc(4'b0000, 1'b0, "rc_count");
    cyc(4'b0000, 1'b0, "rc_hold");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      cyc(v, ($urandom_range(0, 15) == 0), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_toggle();
    test_saturate();
    test_reset_conflict();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
